// File: rtl/vga_pkg.sv
// VGA timing package: region encoding and
// 640x480@60 default timing constants.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } region_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter, region FSM,
// registered sync level and wrap carry-out.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT   = DEF_H_ACTIVE,
  parameter int FP    = DEF_H_FP,
  parameter int SW    = DEF_H_SYNC,
  parameter int BP    = DEF_H_BP,
  parameter bit POL   = 1'b0,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output region_t          region_nxt,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACT, FP, SW, BP);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] F0 =
    CNT_W'(ACT);
  localparam logic [CNT_W-1:0] S0 =
    CNT_W'(ACT + FP);
  localparam logic [CNT_W-1:0] B0 =
    CNT_W'(ACT + FP + SW);

  region_t          region;
  logic [CNT_W-1:0] count_nxt;

  assign wrap = adv && (count == LAST);

  // next position: step on advance, wrap at the end
  always_comb begin
    count_nxt = count;
    if (adv) begin
      count_nxt = wrap ? '0 : count + CNT_W'(1);
    end
  end

  // region follows the count being loaded; later
  // region wins so a zero-length porch is skipped
  always_comb begin
    region_nxt = region;
    if (adv) begin
      if (count_nxt == '0) begin
        region_nxt = ACTIVE;
      end else if (count_nxt == B0) begin
        region_nxt = BACK;
      end else if (count_nxt == S0) begin
        region_nxt = SYNC;
      end else if (count_nxt == F0) begin
        region_nxt = FRONT;
      end
    end
  end

  // count, region and sync update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      region <= ACTIVE;
      sync   <= ~POL;
    end else begin
      count  <= count_nxt;
      region <= region_nxt;
      sync   <= (region_nxt == SYNC) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider feeding
// chained H and V axis counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             enable,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             adv;
  logic             h_wrap;
  logic             v_wrap;
  region_t          h_rn;
  region_t          v_rn;

  assign adv = (div == DIV_LAST);

  // pixel divider: 0..CLK_DIV-1, advance on last
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else begin
      div <= adv ? '0 : div + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .ACT  (H_ACTIVE),
    .FP   (H_FP),
    .SW   (H_SYNC),
    .BP   (H_BP),
    .POL  (SYNC_POL),
    .CNT_W(CNT_W)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .count     (hcount),
    .region_nxt(h_rn),
    .sync      (hsync),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .ACT  (V_ACTIVE),
    .FP   (V_FP),
    .SW   (V_SYNC),
    .BP   (V_BP),
    .POL  (SYNC_POL),
    .CNT_W(CNT_W)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .adv       (h_wrap),
    .count     (vcount),
    .region_nxt(v_rn),
    .sync      (vsync),
    .wrap      (v_wrap)
  );

  // pulses and enable aligned with the new counts
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      enable      <= 1'b0;
    end else begin
      pix_tick    <= adv;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      enable      <= (h_rn == ACTIVE) &&
                     (v_rn == ACTIVE);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle-count reference
// model scoreboard plus directed boundary checks.
module tb_vga_timing_gen;

  typedef logic [25:0] ov_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic hs_a, vs_a, en_a, pt_a, ls_a, fs_a;
  logic hs_b, vs_b, en_b, pt_b, ls_b, fs_b;
  logic hs_c, vs_c, en_c, pt_c, ls_c, fs_c;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_a),
    .hcount(hc_a), .vcount(vc_a),
    .hsync(hs_a), .vsync(vs_a),
    .enable(en_a), .pix_tick(pt_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .CLK_DIV(2), .CNT_W(10)
  ) u_sml (
    .clk(clk), .rst(rst_b),
    .hcount(hc_b), .vcount(vc_b),
    .hsync(hs_b), .vsync(vs_b),
    .enable(en_b), .pix_tick(pt_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_FP(0), .SYNC_POL(1'b1),
    .CLK_DIV(1), .CNT_W(10)
  ) u_fast (
    .clk(clk), .rst(rst_c),
    .hcount(hc_c), .vcount(vc_c),
    .hsync(hs_c), .vsync(vs_c),
    .enable(en_c), .pix_tick(pt_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  int checks = 0;
  int fails  = 0;
  int n_a, n_b, n_c;
  ov_t q_a[$], q_b[$], q_c[$];

  // expected outputs from elapsed clocks since reset
  function automatic ov_t model(
    input int d, ha, hf, hs, hb,
    input int va, vf, vs, vb,
    input bit pol,
    input int n
  );
    int ht, vt, p, h, v;
    bit tk, hy, vy, en, ls, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = n / d;
    h  = p % ht;
    v  = (p / ht) % vt;
    tk = (n > 0) && (n % d == 0);
    hy = (h >= ha + hf && h < ha + hf + hs)
         ? pol : !pol;
    vy = (v >= va + vf && v < va + vf + vs)
         ? pol : !pol;
    en = (n > 0) && (h < ha) && (v < va);
    ls = tk && (h == 0);
    fs = ls && (v == 0);
    return {10'(h), 10'(v), hy, vy, en, tk, ls, fs};
  endfunction

  task automatic check(
    input string tag,
    input ov_t obs,
    input ov_t exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check1(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // one clock: push expectations, compare at negedge
  task automatic step();
    @(posedge clk);
    n_a = rst_a ? 0 : n_a + 1;
    n_b = rst_b ? 0 : n_b + 1;
    n_c = rst_c ? 0 : n_c + 1;
    q_a.push_back(model(2, 640, 16, 96, 48,
                        480, 10, 2, 33, 1'b0, n_a));
    q_b.push_back(model(2, 20, 2, 3, 2,
                        8, 1, 2, 3, 1'b0, n_b));
    q_c.push_back(model(1, 640, 0, 96, 48,
                        480, 10, 2, 33, 1'b1, n_c));
    @(negedge clk);
    check("seq_def",
          {hc_a, vc_a, hs_a, vs_a, en_a, pt_a, ls_a, fs_a},
          q_a.pop_front());
    check("seq_small",
          {hc_b, vc_b, hs_b, vs_b, en_b, pt_b, ls_b, fs_b},
          q_b.pop_front());
    check("seq_fast",
          {hc_c, vc_c, hs_c, vs_c, en_c, pt_c, ls_c, fs_c},
          q_c.pop_front());
  endtask

  initial begin
    int hs_low, first_low, last_low;
    int hs_hi, first_hi, ticks_c, ls_cnt_b;
    int fs_n[$];
    bit prev_en_a, prev_en_b, drop_b;
    bit seen_640, seen_v8, seen_eof, found;

    hs_low = 0; first_low = -1; last_low = -1;
    hs_hi = 0; first_hi = -1; ticks_c = 0;
    ls_cnt_b = 0; drop_b = 1'b0;
    seen_640 = 1'b0; seen_v8 = 1'b0;
    seen_eof = 1'b0; found = 1'b0;
    n_a = 0; n_b = 0; n_c = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    repeat (3) step();
    check1("rst_enable", en_a, 0);
    check1("rst_hsync", hs_a, 1);
    check1("rst_hsync_pol1", hs_c, 0);
    check1("rst_tick", pt_a, 0);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    step();
    check1("first_clk_enable", en_a, 1);
    check1("first_clk_tick_div2", pt_a, 0);
    check1("first_clk_tick_div1", pt_c, 1);
    step();
    check1("second_clk_tick_div2", pt_a, 1);
    check1("second_clk_hcount", hc_a, 1);
    prev_en_a = en_a;
    prev_en_b = en_b;

    for (int i = 0; i < 1700; i++) begin
      step();
      if (vc_a == 0 && hs_a == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(hc_a);
        last_low = int'(hc_a);
      end
      if (pt_a && hc_a == 640 && vc_a == 0) begin
        seen_640 = 1'b1;
        check1("en_at_640_0", en_a, 0);
        check1("en_at_639_0", prev_en_a, 1);
      end
      if (pt_a && hc_a == 0 && vc_a == 1) begin
        check1("line1_line_start", ls_a, 1);
        check1("line1_frame_start", fs_a, 0);
      end
      if (drop_b) begin
        check1("eof_ls_one_clk", ls_b, 0);
        check1("eof_fs_one_clk", fs_b, 0);
        drop_b = 1'b0;
      end
      if (fs_b) fs_n.push_back(n_b);
      if (ls_b) ls_cnt_b++;
      if (pt_b && hc_b == 0 && vc_b == 0) begin
        seen_eof = 1'b1;
        check1("eof_line_start", ls_b, 1);
        check1("eof_frame_start", fs_b, 1);
        drop_b = 1'b1;
      end
      if (pt_b && hc_b == 0 && vc_b == 8) begin
        seen_v8 = 1'b1;
        check1("en_at_0_vlast", en_b, 0);
        check1("en_before_vlast", prev_en_b, 0);
      end
      if (vc_c == 0 && hs_c == 1'b1) begin
        hs_hi++;
        if (first_hi < 0) first_hi = int'(hc_c);
      end
      if (pt_c) ticks_c++;
      if (hc_c == 640 && vc_c == 0) begin
        check1("fast_no_front", hs_c, 1);
      end
      prev_en_a = en_a;
      prev_en_b = en_b;
    end

    check1("hsync_low_clks", hs_low, 192);
    check1("hsync_first_low", first_low, 656);
    check1("hsync_last_low", last_low, 751);
    check1("saw_640_edge", seen_640, 1);
    check1("saw_vlast_edge", seen_v8, 1);
    check1("saw_eof", seen_eof, 1);
    check1("small_line_starts", ls_cnt_b, 31);
    check1("frame_starts", fs_n.size(), 2);
    if (fs_n.size() >= 2) begin
      check1("first_frame_start", fs_n[0], 756);
      check1("frame_period", fs_n[1] - fs_n[0], 756);
    end
    check1("fast_ticks", ticks_c, 1700);
    check1("fast_hsync_high", hs_hi, 96);
    check1("fast_hsync_first", first_hi, 640);

    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (hc_a == 700 && vc_a == 1) found = 1'b1;
    end
    check1("reach_700_1", found, 1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    check1("midrst_hcount", hc_a, 0);
    check1("midrst_vcount", vc_a, 0);
    check1("midrst_enable", en_a, 0);
    check1("midrst_hsync", hs_a, 1);
    check1("midrst_vsync", vs_a, 1);
    check1("midrst_line_start", ls_a, 0);
    check1("midrst_frame_start", fs_a, 0);
    check1("midrst_tick", pt_a, 0);
    check1("midrst_small_v", vc_b, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    check1("rerelease_enable", en_a, 1);
    step();
    check1("rerelease_tick", pt_a, 1);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
